lcd_write_sequencer: RTL

LCD_WRITE_SEQUENCER -- requirements
Module: lcd_write_sequencer

---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_write_sequencer_if.sv | 24 ++
 rtl/lcd_enable_pulse.sv | 51 +++++
 rtl/lcd_write_sequencer.sv | 127 ++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared state encodings, strobe phases and default timing constants for the
// HD44780-style 4-bit LCD write sequencer.
package lcd_pkg;

    localparam int unsigned CNT_W         = 16;
    localparam int unsigned DEF_SETUP_CYC = 2;
    localparam int unsigned DEF_PULSE_CYC = 12;
    localparam int unsigned DEF_HOLD_CYC  = 1;
    localparam int unsigned DEF_GAP_CYC   = 50;
    localparam int unsigned DEF_WAIT_CYC  = 2000;

    typedef logic [CNT_W-1:0] cycCount_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HI_SETUP,
        S_HI_PULSE,
        S_HI_HOLD,
        S_GAP,
        S_LO_SETUP,
        S_LO_PULSE,
        S_LO_HOLD,
        S_WAIT,
        S_DONE
    } seqState_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } strobePhase_t;

    // Counter value seen in the final cycle of a state lasting `cycles` cycles.
    function automatic cycCount_t lastCount(input int unsigned cycles);
        return cycCount_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/lcd_write_sequencer_if.sv
// Host request / LCD bus bundle for lcd_write_sequencer.
interface lcd_write_sequencer_if;

    logic       iStart;
    logic [7:0] iData;
    logic       iRS;
    logic       oBusy;
    logic       oDone;
    logic [3:0] oLCD_Data;
    logic       oLCD_RS;
    logic       oLCD_RW;
    logic       oLCD_E;

    modport master (
        output iStart, iData, iRS,
        input  oBusy, oDone, oLCD_Data, oLCD_RS, oLCD_RW, oLCD_E
    );

    modport slave (
        input  iStart, iData, iRS,
        output oBusy, oDone, oLCD_Data, oLCD_RS, oLCD_RW, oLCD_E
    );

endinterface

// File: rtl/lcd_enable_pulse.sv
// Setup / pulse / hold timing of one E strobe, paced by the sequencer's shared
// cycle counter (which the sequencer clears on every phase entry).
module lcd_enable_pulse
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
    parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic      Clock,
    input  logic      Reset,
    input  logic      iTrigger,
    input  cycCount_t iCount,
    output logic      oE,
    output logic      oSetupEnd,
    output logic      oPulseEnd,
    output logic      oDone
);

    localparam cycCount_t SETUP_LAST = lastCount(SETUP_CYC);
    localparam cycCount_t PULSE_LAST = lastCount(PULSE_CYC);
    localparam cycCount_t HOLD_LAST  = lastCount(HOLD_CYC);

    strobePhase_t phase;

    // Last-cycle flags let the sequencer change state on the same edge.
    assign oSetupEnd = (phase == PH_SETUP) && (iCount == SETUP_LAST);
    assign oPulseEnd = (phase == PH_PULSE) && (iCount == PULSE_LAST);
    assign oDone     = (phase == PH_HOLD)  && (iCount == HOLD_LAST);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            phase <= PH_IDLE;
            oE    <= 1'b0;
        end else begin
            unique case (phase)
                PH_IDLE:  if (iTrigger) phase <= PH_SETUP;
                PH_SETUP: if (oSetupEnd) begin
                    phase <= PH_PULSE;
                    oE    <= 1'b1;
                end
                PH_PULSE: if (oPulseEnd) begin
                    phase <= PH_HOLD;
                    oE    <= 1'b0;
                end
                PH_HOLD:  if (oDone) phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_write_sequencer.sv
// Writes one byte to a 4-bit LCD bus as two E-strobed nibbles (upper first),
// followed by the command-execution wait and a one-cycle oDone.
module lcd_write_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
    parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
    parameter int unsigned GAP_CYC   = DEF_GAP_CYC,
    parameter int unsigned WAIT_CYC  = DEF_WAIT_CYC
) (
    input  logic                 Clock,
    input  logic                 Reset,
    lcd_write_sequencer_if.slave bus
);

    localparam cycCount_t GAP_LAST  = lastCount(GAP_CYC);
    localparam cycCount_t WAIT_LAST = lastCount(WAIT_CYC);

    seqState_t  state;
    cycCount_t  count;
    logic [3:0] loNibble;
    logic [3:0] lcdData;
    logic       lcdRs;
    logic       busy;
    logic       done;
    logic       lcdE;
    logic       strobeGo;
    logic       setupEnd;
    logic       pulseEnd;
    logic       strobeDone;

    assign strobeGo = ((state == S_IDLE) && bus.iStart) ||
                      ((state == S_GAP) && (count == GAP_LAST));

    lcd_enable_pulse #(
        .SETUP_CYC(SETUP_CYC),
        .PULSE_CYC(PULSE_CYC),
        .HOLD_CYC (HOLD_CYC)
    ) uStrobe (
        .Clock    (Clock),
        .Reset    (Reset),
        .iTrigger (strobeGo),
        .iCount   (count),
        .oE       (lcdE),
        .oSetupEnd(setupEnd),
        .oPulseEnd(pulseEnd),
        .oDone    (strobeDone)
    );

    // The upper nibble is latched straight into the data register; only the
    // lower nibble needs separate storage until GAP.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= S_IDLE;
            count    <= '0;
            loNibble <= '0;
            lcdData  <= '0;
            lcdRs    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            count <= count + cycCount_t'(1);
            unique case (state)
                S_IDLE: begin
                    count <= '0;
                    if (bus.iStart) begin
                        state    <= S_HI_SETUP;
                        busy     <= 1'b1;
                        lcdData  <= bus.iData[7:4];
                        loNibble <= bus.iData[3:0];
                        lcdRs    <= bus.iRS;
                    end
                end
                S_HI_SETUP: if (setupEnd) begin
                    state <= S_HI_PULSE;
                    count <= '0;
                end
                S_HI_PULSE: if (pulseEnd) begin
                    state <= S_HI_HOLD;
                    count <= '0;
                end
                S_HI_HOLD: if (strobeDone) begin
                    state   <= S_GAP;
                    count   <= '0;
                    lcdData <= loNibble;
                end
                S_GAP: if (count == GAP_LAST) begin
                    state <= S_LO_SETUP;
                    count <= '0;
                end
                S_LO_SETUP: if (setupEnd) begin
                    state <= S_LO_PULSE;
                    count <= '0;
                end
                S_LO_PULSE: if (pulseEnd) begin
                    state <= S_LO_HOLD;
                    count <= '0;
                end
                S_LO_HOLD: if (strobeDone) begin
                    state <= S_WAIT;
                    count <= '0;
                end
                S_WAIT: if (count == WAIT_LAST) begin
                    state <= S_DONE;
                    count <= '0;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    count <= '0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.oBusy     = busy;
    assign bus.oDone     = done;
    assign bus.oLCD_Data = lcdData;
    assign bus.oLCD_RS   = lcdRs;
    assign bus.oLCD_RW   = 1'b0;
    assign bus.oLCD_E    = lcdE;

endmodule
